// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl_pkg                                           |
// | Description : Shared definitions for the ALU issue controller: 5-bit ALU   |
// |               opcode constants, opcode-class helpers and the FSM state     |
// |               encoding.                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_issue_ctrl_pkg;

  localparam logic [4:0] c_OP_ADD   = 5'd0;
  localparam logic [4:0] c_OP_SUB   = 5'd1;
  localparam logic [4:0] c_OP_INC   = 5'd2;
  localparam logic [4:0] c_OP_DEC   = 5'd3;
  localparam logic [4:0] c_OP_MUL   = 5'd4;
  localparam logic [4:0] c_OP_FPA   = 5'd5;
  localparam logic [4:0] c_OP_FPS   = 5'd6;
  localparam logic [4:0] c_OP_FPM   = 5'd7;
  localparam logic [4:0] c_OP_AND   = 5'd8;
  localparam logic [4:0] c_OP_OR    = 5'd9;
  localparam logic [4:0] c_OP_XOR   = 5'd10;
  localparam logic [4:0] c_OP_NOT   = 5'd11;
  localparam logic [4:0] c_OP_SHL   = 5'd12;
  localparam logic [4:0] c_OP_SHR   = 5'd13;
  localparam logic [4:0] c_OP_ROL   = 5'd14;
  localparam logic [4:0] c_OP_NEG   = 5'd15;
  localparam logic [4:0] c_OP_LOAD  = 5'd16;
  localparam logic [4:0] c_OP_STORE = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Floating-point units are pipelined and need the latency counter.
  function automatic logic is_fp(input logic [4:0] op);
    return (op == c_OP_FPA) || (op == c_OP_FPS) || (op == c_OP_FPM);
  endfunction

  // Everything from LOAD upward has no ALU implementation behind it.
  function automatic logic is_illegal(input logic [4:0] op);
    return op[4];
  endfunction

  // Only the add/sub family produces a meaningful bit 32.
  function automatic logic has_carry(input logic [4:0] op);
    return (op[4:2] == 3'b000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl_if                                            |
// | Description : Bus bundle of the ALU issue controller: instruction          |
// |               handshake, host register-file write port, ALU operand /      |
// |               result path and writeback report.                            |
// |               slave  : controller side                                     |
// |               master : host / ALU side                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  instr_op;
  logic [4:0]  instr_rd;
  logic [4:0]  instr_rs1;
  logic [4:0]  instr_rs2;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_carry;
  logic        wb_err;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  cfg_we, cfg_addr, cfg_data, alu_out,
    output instr_ready, alu_a, alu_b, alu_opcode,
    output wb_valid, wb_rd, wb_data, wb_carry, wb_err
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output cfg_we, cfg_addr, cfg_data, alu_out,
    input  instr_ready, alu_a, alu_b, alu_opcode,
    input  wb_valid, wb_rd, wb_data, wb_carry, wb_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_regfile                                                  |
// | Description : NREGS x 32 register file, two asynchronous read ports and a  |
// |               writeback / host-config write path. When both target the     |
// |               same entry in one cycle the writeback value is kept.         |
// |               Entry 0 always reads zero.                                   |
// | Ports       : clk, rst_n (async, active low, clears all entries)           |
// |               rd_addr_a/b -> rd_data_a/b  operand reads                    |
// |               wb_we/wb_addr/wb_data       instruction writeback            |
// |               cfg_we/cfg_addr/cfg_data    host write                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data
);

  localparam int c_IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [31:0] r_regs [NREGS];

  // Entry 0 is cleared by reset and never written, so it reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_we && (wb_addr == 5'(i))) begin
          r_regs[i] <= wb_data;
        end else if (cfg_we && (cfg_addr == 5'(i))) begin
          r_regs[i] <= cfg_data;
        end
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (32'(rd_addr_a) < NREGS) rd_data_a = r_regs[rd_addr_a[c_IDX_W-1:0]];
    if (32'(rd_addr_b) < NREGS) rd_data_b = r_regs[rd_addr_b[c_IDX_W-1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl                                               |
// | Description : Issues one instruction at a time to the 32-bit ALU: reads    |
// |               operands from the internal register file, waits the          |
// |               opcode-dependent latency, captures the 64-bit result,        |
// |               writes the low word back and pulses wb_valid.                |
// | Ports       : clk, rst_n (async, active low)                               |
// |               bus (alu_issue_ctrl_if.slave): instr_*, cfg_*, alu_*, wb_*   |
// |               perf_instr, perf_busy - only with ALU_ISSUE_PERF_EN defined  |
// | Options     : `define ALU_ISSUE_PERF_EN adds saturating counters of        |
// |               completed instructions and busy cycles.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int FP_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_instr,
  output logic [31:0]     perf_busy
`endif
);

  localparam int                 c_CNT_W    = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(FP_LAT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_xfer;
  logic               w_capture;
  logic               w_illegal_exec;
  logic               w_ready;
  logic               w_wb_valid;
  logic               w_wb_we;
  logic [c_CNT_W-1:0] r_cnt;
  logic [4:0]         r_rd;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [4:0]         r_alu_opcode;
  logic [4:0]         r_wb_rd;
  logic [63:0]        r_wb_data;
  logic               r_wb_carry;
  logic               r_wb_err;
  logic [31:0]        w_rs1_data;
  logic [31:0]        w_rs2_data;

  alu_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (bus.instr_rs1),
    .rd_addr_b (bus.instr_rs2),
    .rd_data_a (w_rs1_data),
    .rd_data_b (w_rs2_data),
    .wb_we     (w_wb_we),
    .wb_addr   (r_wb_rd),
    .wb_data   (r_wb_data[31:0]),
    .cfg_we    (bus.cfg_we),
    .cfg_addr  (bus.cfg_addr),
    .cfg_data  (bus.cfg_data)
  );

  assign w_xfer         = bus.instr_valid && w_ready;
  assign w_illegal_exec = (r_state == ST_EXEC) && is_illegal(r_alu_opcode);
  // The counter is loaded at transfer and runs through EXEC and WAIT, so
  // an FP result is captured FP_LAT cycles after the transfer cycle.
  assign w_capture = ((r_state == ST_EXEC) && !is_illegal(r_alu_opcode) &&
                      (!is_fp(r_alu_opcode) || (r_cnt == '0))) ||
                     ((r_state == ST_WAIT) && (r_cnt == '0));
  assign w_wb_we   = (r_state == ST_WB) && !r_wb_err && (r_wb_rd != 5'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer) w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (is_illegal(r_alu_opcode) || w_capture) w_next_state = ST_WB;
        else                                       w_next_state = ST_WAIT;
      end
      ST_WAIT: if (w_capture) w_next_state = ST_WB;
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs; ready is also held low while reset is asserted.
  always_comb begin
    w_ready    = 1'b0;
    w_wb_valid = 1'b0;
    if (r_state == ST_IDLE) w_ready    = rst_n;
    if (r_state == ST_WB)   w_wb_valid = 1'b1;
  end

  // Operand, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_rd         <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_wb_carry   <= 1'b0;
      r_wb_err     <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_alu_a      <= w_rs1_data;
        r_alu_b      <= w_rs2_data;
        r_alu_opcode <= bus.instr_op;
        r_rd         <= bus.instr_rd;
        r_cnt        <= c_CNT_INIT;
      end else if (((r_state == ST_EXEC) || (r_state == ST_WAIT)) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end

      if (w_capture) begin
        r_wb_rd    <= r_rd;
        r_wb_data  <= bus.alu_out;
        r_wb_carry <= has_carry(r_alu_opcode) & bus.alu_out[32];
        r_wb_err   <= 1'b0;
      end else if (w_illegal_exec) begin
        r_wb_rd    <= r_rd;
        r_wb_data  <= '0;
        r_wb_carry <= 1'b0;
        r_wb_err   <= 1'b1;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.wb_valid    = w_wb_valid;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_carry    = r_wb_carry;
  assign bus.wb_err      = r_wb_err;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_instr;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_instr <= '0;
      r_perf_busy  <= '0;
    end else begin
      if ((r_state == ST_WB) && (r_perf_instr != '1)) r_perf_instr <= r_perf_instr + 32'd1;
      if ((r_state != ST_IDLE) && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_instr = r_perf_instr;
  assign perf_busy  = r_perf_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_ctrl                                            |
// | Description : Directed bench for alu_issue_ctrl. The bench plays host and  |
// |               ALU: it presents the hand-computed ALU result only in the    |
// |               cycle the result must be captured, and reads register        |
// |               contents back through the operand path of probe issues.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int          FP_LAT = 4;
  localparam logic [63:0] JUNK   = 64'hDEAD_BEEF_5A5A_A5A5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_instr;
  logic [31:0] perf_busy;
`endif

  alu_issue_ctrl #(
    .NREGS  (32),
    .FP_LAT (FP_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_instr (perf_instr),
    .perf_busy  (perf_busy)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic [63:0] res, input int lat,
                       input logic [63:0] ed, input logic ec, input logic ee,
                       input logic wbcfg, input logic [4:0] wbcfg_a, input logic [31:0] wbcfg_d);
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs1   = rs1;
    bus.instr_rs2   = rs2;
    bus.alu_out     = JUNK;
    @(negedge clk);
    chk({tag, " ready"}, 64'(bus.instr_ready), 64'd1);
    @(posedge clk); #1;
    for (int c = 1; c <= lat; c++) begin
      // Stray offers while busy must be ignored.
      bus.instr_valid = (c < lat);
      bus.instr_op    = c_OP_SUB;
      bus.instr_rd    = 5'd31;
      bus.instr_rs1   = 5'd1;
      bus.instr_rs2   = 5'd2;
      bus.alu_out     = (c == lat - 1) ? res : JUNK;
      if (wbcfg && (c == lat)) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = wbcfg_a;
        bus.cfg_data = wbcfg_d;
      end
      @(negedge clk);
      if (c < lat) begin
        chk({tag, " alu_a"},      64'(bus.alu_a),      64'(ea));
        chk({tag, " alu_b"},      64'(bus.alu_b),      64'(eb));
        chk({tag, " alu_opcode"}, 64'(bus.alu_opcode), 64'(op));
      end
      chk({tag, " wb_valid"},    64'(bus.wb_valid),    64'(c == lat));
      chk({tag, " busy_ready"},  64'(bus.instr_ready), 64'd0);
      if (c == lat) begin
        chk({tag, " wb_rd"},    64'(bus.wb_rd),    64'(rd));
        chk({tag, " wb_data"},  bus.wb_data,       ed);
        chk({tag, " wb_carry"}, 64'(bus.wb_carry), 64'(ec));
        chk({tag, " wb_err"},   64'(bus.wb_err),   64'(ee));
      end
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
    end
  endtask

  // Reads two registers through the operand path; rd=0 keeps the file intact.
  task automatic probe(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] ea, input logic [31:0] eb);
    issue(tag, c_OP_XOR, 5'd0, rs1, rs2, ea, eb, 64'h1, 2, 64'h1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_rd    = '0;
    bus.instr_rs1   = '0;
    bus.instr_rs2   = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    bus.alu_out     = '0;

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst ready",      64'(bus.instr_ready), 64'd0);
    chk("rst wb_valid",   64'(bus.wb_valid),    64'd0);
    chk("rst wb_data",    bus.wb_data,          64'd0);
    chk("rst wb_rd",      64'(bus.wb_rd),       64'd0);
    chk("rst wb_err",     64'(bus.wb_err),      64'd0);
    chk("rst wb_carry",   64'(bus.wb_carry),    64'd0);
    chk("rst alu_a",      64'(bus.alu_a),       64'd0);
    chk("rst alu_opcode", 64'(bus.alu_opcode),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst ready", 64'(bus.instr_ready), 64'd1);
    @(posedge clk); #1;

    // ADD 5+7
    cfg_write(5'd1, 32'd5);
    cfg_write(5'd2, 32'd7);
    issue("add", c_OP_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 64'hC, 2, 64'hC, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    probe("probe r3", 5'd3, 5'd0, 32'd12, 32'd0);

    // ADD with carry out, SUB with borrow
    cfg_write(5'd1, 32'hFFFF_FFFF);
    cfg_write(5'd2, 32'd1);
    issue("add carry", c_OP_ADD, 5'd4, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1,
          64'h0000_0001_0000_0000, 2, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    issue("sub", c_OP_SUB, 5'd5, 5'd2, 5'd1, 32'd1, 32'hFFFF_FFFF,
          64'h0000_0001_0000_0002, 2, 64'h0000_0001_0000_0002, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    probe("probe r4 r5", 5'd4, 5'd5, 32'd0, 32'd2);

    // MUL: bit 32 set but not a carry opcode
    cfg_write(5'd1, 32'h0001_0000);
    cfg_write(5'd2, 32'h0001_0000);
    issue("mul", c_OP_MUL, 5'd6, 5'd1, 5'd2, 32'h0001_0000, 32'h0001_0000,
          64'h0000_0001_0000_0000, 2, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    probe("probe r6", 5'd6, 5'd0, 32'd0, 32'd0);

    // FPA 1.0 + 2.0 = 3.0, FP_LAT+1 cycle latency
    cfg_write(5'd1, 32'h3F80_0000);
    cfg_write(5'd2, 32'h4000_0000);
    issue("fpa", c_OP_FPA, 5'd7, 5'd1, 5'd2, 32'h3F80_0000, 32'h4000_0000,
          64'h4040_0000, FP_LAT + 1, 64'h4040_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    probe("probe r7", 5'd7, 5'd0, 32'h4040_0000, 32'd0);

    // Illegal opcode: no capture, no writeback
    cfg_write(5'd8, 32'h1234);
    issue("illegal", c_OP_LOAD, 5'd8, 5'd1, 5'd2, 32'h3F80_0000, 32'h4000_0000,
          JUNK, 2, 64'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    probe("probe r8", 5'd8, 5'd0, 32'h1234, 32'd0);

    // Register 0 ignores cfg and writeback
    cfg_write(5'd0, 32'hFFFF);
    issue("add rd0", c_OP_ADD, 5'd0, 5'd8, 5'd8, 32'h1234, 32'h1234,
          64'h2468, 2, 64'h2468, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    probe("probe r0", 5'd0, 5'd0, 32'd0, 32'd0);

    // cfg in the WB cycle: same rd loses, different address lands
    issue("wb vs cfg", c_OP_ADD, 5'd9, 5'd7, 5'd8, 32'h4040_0000, 32'h1234,
          64'h4040_1234, 2, 64'h4040_1234, 1'b0, 1'b0, 1'b1, 5'd9, 32'h5555);
    issue("wb + cfg", c_OP_AND, 5'd10, 5'd7, 5'd8, 32'h4040_0000, 32'h1234,
          64'h0000_0000, 2, 64'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd11, 32'h77);
    probe("probe r9 r11", 5'd9, 5'd11, 32'h4040_1234, 32'h77);

    // Reset during the WAIT phase of an FPM
    bus.instr_valid = 1'b1;
    bus.instr_op    = c_OP_FPM;
    bus.instr_rd    = 5'd12;
    bus.instr_rs1   = 5'd1;
    bus.instr_rs2   = 5'd2;
    bus.alu_out     = JUNK;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-rst wb_valid", 64'(bus.wb_valid),    64'd0);
    chk("mid-rst ready",    64'(bus.instr_ready), 64'd0);
    chk("mid-rst wb_data",  bus.wb_data,          64'd0);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus.alu_out = 64'h4080_0000;
    @(negedge clk);
    chk("after-rst ready", 64'(bus.instr_ready), 64'd1);
    for (int i = 0; i < FP_LAT + 2; i++) begin
      chk("after-rst no wb", 64'(bus.wb_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    probe("probe cleared r1 r2", 5'd1, 5'd2, 32'd0, 32'd0);
    probe("probe cleared r9 r12", 5'd9, 5'd12, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Drives the 32-bit ALU from the other side of its operand/opcode/result interface.
- Accepts one instruction at a time (opcode, rd, rs1, rs2) over a valid/ready handshake.
- Reads operands from an internal 32x32 register file, presents A/B/opcode to the ALU, and waits an opcode-dependent latency (FP units are clocked).
- Captures the 64-bit ALU result, writes the low word back to rd, and reports completion on a one-cycle writeback strobe.

Parameters:
- NREGS, 32, register file depth (power of two, max 32; index width 5).
- FP_LAT, 4, cycles from operand presentation to a valid FPA/FPS/FPM result (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- instr_op  in  5  ALU opcode.
- instr_rd  in  5  destination register.
- instr_rs1  in  5  source register for A.
- instr_rs2  in  5  source register for B.
- cfg_we  in  1  host register write strobe.
- cfg_addr  in  5  host write index.
- cfg_data  in  32  host write data.
- alu_a  out  32  operand A to ALU.
- alu_b  out  32  operand B to ALU.
- alu_opcode  out  5  opcode to ALU.
- alu_out  in  64  ALU result.
- wb_valid  out  1  one-cycle completion pulse.
- wb_rd  out  5  destination of the completed instruction.
- wb_data  out  64  full captured ALU result.
- wb_carry  out  1  alu_out[32] for opcodes 0-3, else 0.
- wb_err  out  1  illegal opcode flag, valid with wb_valid.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; register file cleared to 0.
- instr_ready=1 only in IDLE. Transfer occurs when instr_valid && instr_ready.
- FSM states: IDLE -> EXEC -> (WAIT) -> WB -> IDLE.
- IDLE: on transfer, latch op/rd/rs1/rs2 and read rs1/rs2 into alu_a/alu_b registers. The read uses register contents before any same-cycle cfg write. Load alu_opcode.
- EXEC, integer/logic ops (opcode 0-4, 8-15): capture alu_out at the end of EXEC, then go to WB. Transfer-to-wb_valid latency is 2 cycles.
- EXEC, FP ops (5-7): go to WAIT. A counter loads FP_LAT-1 and decrements; at 0, capture alu_out and go to WB. Latency is FP_LAT+1 cycles.
- EXEC, opcode >=16 (LOAD/STORE unsupported): no capture, go to WB with wb_err=1 and wb_data=0.
- alu_a/alu_b/alu_opcode are held stable from EXEC through the capture cycle.
- WB: wb_valid=1 for exactly one cycle; wb_rd/wb_data/wb_carry/wb_err held until the next WB.
  - Write wb_data[31:0] to rd unless wb_err or rd==0.
- Register 0 always reads 0; writes to it (writeback or cfg) are dropped.
- cfg writes are accepted in any state. If cfg_addr equals the writeback rd in the WB cycle, the writeback wins.
- Back-to-back: a new instruction can transfer the cycle after WB (IDLE). There is no overlap and no forwarding; operands always read the updated file.
- instr_valid while not ready: ignored; the instruction is not captured.
- Reset asserted mid-EXEC/WAIT/WB: immediate return to IDLE, no writeback, wb_valid=0, register file cleared.

Optional Feature:
- ALU_ISSUE_PERF_EN defined: adds outputs perf_instr (32b, increments on each WB) and perf_busy (32b, increments every cycle FSM != IDLE). Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists.

Decomposition:
- Shared package alu_pkg: 5-bit opcode constants (ADD..NEG, LOAD, STORE), opcode-class helper (is_fp, is_illegal, has_carry), and FSM state enum.
- One natural sub-module: alu_regfile (2 async read ports, 1 write port with writeback-over-cfg priority, r0 hardwired zero).
- Latency counter and FSM stay in the top module.

Test Plan:
- cfg r1=5, r2=7; issue ADD rd=3 -> wb_valid 2 cycles after transfer, wb_data=0x0000_0000_0000_000C, wb_carry=0, r3=12.
- r1=0xFFFF_FFFF, r2=1, ADD rd=4 -> wb_carry=1, r4=0; then SUB r2-r1 into rd=5 -> r5=2.
- r1=r2=0x0001_0000, MUL rd=6 -> wb_data=0x0000_0001_0000_0000, r6=0.
- r1=0x3F80_0000, r2=0x4000_0000, FPA rd=7 -> wb_valid exactly FP_LAT+1 cycles after transfer, r7=0x4040_0000; instr_ready=0 throughout.
- Opcode 5'b10000 rd=8 -> wb_err=1, wb_data=0, r8 unchanged. ADD with rd=0 -> r0 still reads 0.
- Assert rst_n low during WAIT of FPM -> next cycle instr_ready=1, no wb_valid, all registers 0. Same-cycle cfg to rd during WB -> writeback value retained.
